spi_regfile_periph: RTL and testbench

// Parametrised SPI register-file peripheral: whole block in the iclk domain; sclk/serial_in are oversampled pins.

---
 rtl/spi_regfile_periph_pkg.sv | 23 ++
 rtl/spi_regfile_periph_if.sv | 11 +
 rtl/spi_regfile_periph_pin_sync.sv | 31 +++
 rtl/spi_regfile_periph.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_periph_pkg.sv
// Shared types and default constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_NUM_REGS    = 66;
  localparam int DEF_INST_ADDR   = 2;
  localparam int DEF_NUM_INST    = 4;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam logic [DEF_NUM_REGS-1:0] DEF_RO_MASK = 66'h1 << 60;

  // Number of bits needed to hold the values 0..maxCount.
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/spi_regfile_periph_if.sv
// Serial pin bundle of the SPI register-file peripheral.
interface spi_regfile_periph_if;

  logic sclk;
  logic serial_in;
  logic serial_out;

  modport master (output sclk, output serial_in, input serial_out);
  modport slave  (input sclk, input serial_in, output serial_out);

endinterface

// File: rtl/spi_regfile_periph_pin_sync.sv
// Two-flop synchronisers for the asynchronous SPI pins plus sclk edge strobes.
// A pin edge shows up as a one-cycle strobe that the core samples on the third iclk rise.
module spi_pin_sync (
  input  logic iclk_i,
  input  logic rstn_i,
  input  logic sclk_i,
  input  logic sin_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic sin_o
);

  logic [2:0] sclk_sync_q;
  logic [1:0] sin_sync_q;

  // Shift the pins through the synchroniser chain; bit 2 of sclk keeps the previous level.
  always_ff @(posedge iclk_i) begin
    if (!rstn_i) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      sin_sync_q  <= {sin_sync_q[0], sin_i};
    end
  end

  assign sclk_rise_o =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_o = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign sin_o       =  sin_sync_q[1];

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI register-file peripheral: frame decoder, register array and instruction pulses,
// all in the iclk domain. Frames end when sclk stays idle for TIMEOUT_CYC cycles.
// Optional feature macro: SPI_PARITY_EN (odd parity bit after every data word).
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int                    DATA_W      = DEF_DATA_W,
  parameter int                    ADDR_W      = DEF_ADDR_W,
  parameter int                    NUM_REGS    = DEF_NUM_REGS,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = (NUM_REGS)'(DEF_RO_MASK),
  parameter int                    INST_ADDR   = DEF_INST_ADDR,
  parameter int                    NUM_INST    = DEF_NUM_INST,
  parameter int                    TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         iclk,
  input  logic                         rstn,
  spi_regfile_periph_if.slave          spi,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_INST-1:0]          inst_pulse,
  output logic                         frame_active,
  output logic                         err_parity
);

`ifdef SPI_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int AWORD_W = ADDR_W + 1;
  localparam int SHIFT_W = (AWORD_W > WORD_W) ? AWORD_W : WORD_W;
  localparam int CNT_W   = cntWidth(SHIFT_W);
  localparam int TO_W    = cntWidth(TIMEOUT_CYC);
  localparam int PTR_W   = ADDR_W + 1;

  logic sclk_rise, sclk_fall, sin;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-2:0]  shift_q, shift_d;
  logic [PTR_W-1:0]    addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [TO_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                reload_q, reload_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic                serial_out_q, serial_out_d;
  logic [NUM_INST-1:0] inst_pulse_q, inst_pulse_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [SHIFT_W-1:0]  new_shift;
  logic [DATA_W-1:0]   word_data;
  logic [WORD_W-1:0]   load_word;
  logic [DATA_W-1:0]   rd_data;
  logic                parity_ok, addr_in_range, is_ro, wr_en;

  spi_pin_sync u_pin_sync (
    .iclk_i      (iclk),
    .rstn_i      (rstn),
    .sclk_i      (spi.sclk),
    .sin_i       (spi.serial_in),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .sin_o       (sin)
  );

  // Read-only slices come straight from ro_data; everything else from the stored array.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
    assign regs_o[i*DATA_W +: DATA_W] = RO_MASK[i] ? ro_data[i*DATA_W +: DATA_W] : regs_q[i];
  end

  // Look up the current pointer: read-back value and read-only flag (0 when out of range).
  always_comb begin
    is_ro   = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == PTR_W'(i)) begin
        is_ro   = RO_MASK[i];
        rd_data = regs_o[i*DATA_W +: DATA_W];
      end
    end
  end

  assign addr_in_range = (addr_q < PTR_W'(NUM_REGS));
  assign new_shift     = {shift_q, sin};
  assign word_data     = new_shift[WORD_W-1 -: DATA_W];

`ifdef SPI_PARITY_EN
  logic err_q, err_d;
  assign parity_ok  = (^new_shift[WORD_W-1:0]) == 1'b1;
  assign load_word  = {rd_data, ~^rd_data};
  assign err_parity = err_q;
`else
  assign parity_ok  = 1'b1;
  assign load_word  = rd_data;
  assign err_parity = 1'b0;
`endif

  // Frame decoder: bit counting on sclk rises, read shifting on falls, inactivity timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    idle_cnt_d   = '0;
    reload_d     = reload_q;
    shadow_d     = shadow_q;
    serial_out_d = serial_out_q;
    inst_pulse_d = '0;
    wr_en        = 1'b0;
`ifdef SPI_PARITY_EN
    err_d        = err_q;
`endif

    if (sclk_rise) begin
      shift_d = new_shift[SHIFT_W-2:0];
      case (state_q)
        IDLE: begin
          state_d   = ADDR;
          bit_cnt_d = CNT_W'(1);
        end
        ADDR: begin
          if (bit_cnt_q == CNT_W'(AWORD_W - 1)) begin
            rw_d      = new_shift[ADDR_W];
            addr_d    = {1'b0, new_shift[ADDR_W-1:0]};
            reload_d  = new_shift[ADDR_W];
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
            bit_cnt_d = '0;
            if (addr_in_range) addr_d = addr_q + PTR_W'(1);
            if (rw_q) begin
              reload_d = 1'b1;
            end else if (!parity_ok) begin
`ifdef SPI_PARITY_EN
              err_d = 1'b1;
`endif
            end else if (addr_in_range && !is_ro) begin
              wr_en = 1'b1;
              if (addr_q == PTR_W'(INST_ADDR)) begin
                for (int v = 0; v < NUM_INST; v++) begin
                  if (word_data == DATA_W'(v)) inst_pulse_d[v] = 1'b1;
                end
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (sclk_fall && state_q == DATA && rw_q) begin
      if (reload_q) begin
        serial_out_d = load_word[WORD_W-1];
        shadow_d     = load_word << 1;
        reload_d     = 1'b0;
      end else begin
        serial_out_d = shadow_q[WORD_W-1];
        shadow_d     = shadow_q << 1;
      end
    end

    if (state_q != IDLE && !sclk_rise && !sclk_fall) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_d      = IDLE;
        bit_cnt_d    = '0;
        reload_d     = 1'b0;
        serial_out_d = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      idle_cnt_q   <= '0;
      reload_q     <= 1'b0;
      shadow_q     <= '0;
      serial_out_q <= 1'b0;
      inst_pulse_q <= '0;
`ifdef SPI_PARITY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      idle_cnt_q   <= idle_cnt_d;
      reload_q     <= reload_d;
      shadow_q     <= shadow_d;
      serial_out_q <= serial_out_d;
      inst_pulse_q <= inst_pulse_d;
`ifdef SPI_PARITY_EN
      err_q        <= err_d;
`endif
    end
  end

  // Register array: committed words land at the same edge the instruction pulse starts.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == PTR_W'(i)) regs_q[i] <= word_data;
      end
    end
  end

  assign spi.serial_out = serial_out_q;
  assign inst_pulse     = inst_pulse_q;
  assign frame_active   = (state_q != IDLE);

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: bit-banged SPI frames with hand-computed
// expectations. Build with SPI_PARITY_EN defined to exercise the parity variant.
module tb_spi_regfile_periph;

  localparam int DW = 8;
  localparam int NR = 66;
`ifdef SPI_PARITY_EN
  localparam int WW = 9;
`else
  localparam int WW = 8;
`endif

  logic              iclk = 1'b0;
  logic              rstn;
  logic [NR*DW-1:0]  ro_data;
  logic [NR*DW-1:0]  regs_o;
  logic [3:0]        inst_pulse;
  logic              frame_active;
  logic              err_parity;

  int vectors     = 0;
  int miscompares = 0;
  int pulseCount  = 0;
  logic [3:0]  pulseSeen = '0;
  logic [15:0] rdQ[$];
  logic [7:0]  words[$];

  spi_regfile_periph_if spiBus ();

  spi_regfile_periph dut (
    .iclk         (iclk),
    .rstn         (rstn),
    .spi          (spiBus),
    .ro_data      (ro_data),
    .regs_o       (regs_o),
    .inst_pulse   (inst_pulse),
    .frame_active (frame_active),
    .err_parity   (err_parity)
  );

  always #5 iclk = ~iclk;

  // Record every instruction pulse seen, one sample per cycle.
  always @(negedge iclk) begin
    if (inst_pulse != 4'b0) begin
      pulseCount = pulseCount + 1;
      pulseSeen  = pulseSeen | inst_pulse;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge iclk);
  endtask

  function automatic logic [7:0] reg8(input int idx);
    return regs_o[idx*DW +: DW];
  endfunction

  // Data word as sent on the wire, parity bit appended when enabled.
  function automatic logic [15:0] dataWord(input logic [7:0] d);
`ifdef SPI_PARITY_EN
    return {7'b0, d, ~^d};
`else
    return {8'b0, d};
`endif
  endfunction

  // One sclk period; serial_out is sampled just before the rising edge.
  task automatic sendBit(input logic b, output logic rb);
    spiBus.serial_in = b;
    waitCycles(8);
    rb = spiBus.serial_out;
    spiBus.sclk = 1'b1;
    waitCycles(8);
    spiBus.sclk = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] w, input int n, output logic [15:0] rd);
    logic b;
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sendBit(w[i], b);
      rd[i] = b;
    end
  endtask

  task automatic endFrame(input string tag);
    for (int i = 0; i < 200 && frame_active; i++) @(negedge iclk);
    checkOutput({tag, "_idle"}, {31'b0, frame_active}, 32'd0);
  endtask

  // Full frame: address word, queued data words, then wait for the timeout.
  task automatic applyStimulus(input logic [7:0] aw, input string tag);
    logic [15:0] rd;
    rdQ.delete();
    sendWord({8'b0, aw}, 8, rd);
    foreach (words[k]) begin
      sendWord(dataWord(words[k]), WW, rd);
      rdQ.push_back(rd);
    end
    endFrame(tag);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] dw;
    logic        b;

    rstn = 1'b0;
    spiBus.sclk = 1'b0;
    spiBus.serial_in = 1'b0;
    ro_data = '0;
    ro_data[60*DW +: DW] = 8'h3C;
    waitCycles(3);
    rstn = 1'b1;
    waitCycles(2);

    checkOutput("rst_frame", {31'b0, frame_active}, 32'd0);
    checkOutput("rst_inst", {28'b0, inst_pulse}, 32'd0);
    checkOutput("rst_sout", {31'b0, spiBus.serial_out}, 32'd0);
    checkOutput("rst_err", {31'b0, err_parity}, 32'd0);
    checkOutput("rst_reg1", {24'b0, reg8(1)}, 32'd0);
    checkOutput("rst_ro60", {24'b0, reg8(60)}, 32'h3C);

    // Write 0xA5 to reg 1, checking the exact commit cycle.
    sendWord(16'h0001, 8, rd);
    dw = dataWord(8'hA5);
    for (int i = WW - 1; i >= 1; i--) sendBit(dw[i], b);
    checkOutput("t1_active", {31'b0, frame_active}, 32'd1);
    checkOutput("t1_sout_wr", {31'b0, spiBus.serial_out}, 32'd0);
    spiBus.serial_in = dw[0];
    waitCycles(8);
    spiBus.sclk = 1'b1;
    waitCycles(2);
    checkOutput("t1_before", {24'b0, reg8(1)}, 32'd0);
    waitCycles(1);
    checkOutput("t1_commit", {24'b0, reg8(1)}, 32'hA5);
    waitCycles(5);
    spiBus.sclk = 1'b0;
    endFrame("t1");
    checkOutput("t1_reg0", {24'b0, reg8(0)}, 32'd0);
    checkOutput("t1_reg5", {24'b0, reg8(5)}, 32'd0);

    // Burst from 61 runs into the end of the array and saturates there.
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    applyStimulus(8'd61, "t2");
    checkOutput("t2_r61", {24'b0, reg8(61)}, 32'h11);
    checkOutput("t2_r62", {24'b0, reg8(62)}, 32'h22);
    checkOutput("t2_r63", {24'b0, reg8(63)}, 32'h33);
    checkOutput("t2_r64", {24'b0, reg8(64)}, 32'h44);
    checkOutput("t2_r65", {24'b0, reg8(65)}, 32'h55);
    checkOutput("t2_nowrap0", {24'b0, reg8(0)}, 32'd0);
    checkOutput("t2_nowrap1", {24'b0, reg8(1)}, 32'hA5);

    // Read 60 (read-only) and 61; serial_in data must be ignored.
    words = '{8'hFF, 8'hFF};
    applyStimulus(8'hBC, "t3rd");
    checkOutput("t3_rd60", {16'b0, rdQ[0]}, {16'b0, dataWord(8'h3C)});
    checkOutput("t3_rd61", {16'b0, rdQ[1]}, {16'b0, dataWord(8'h11)});
    checkOutput("t3_r61kept", {24'b0, reg8(61)}, 32'h11);
    words = '{8'hAA};
    applyStimulus(8'hC6, "t3oor");
    checkOutput("t3_rd70", {16'b0, rdQ[0]}, {16'b0, dataWord(8'h00)});
    words = '{8'h77};
    applyStimulus(8'd60, "t3wr");
    checkOutput("t3_ro60", {24'b0, reg8(60)}, 32'h3C);

    // Instruction register pulses.
    pulseCount = 0; pulseSeen = '0;
    words = '{8'h03};
    applyStimulus(8'd2, "t4a");
    checkOutput("t4_reg2", {24'b0, reg8(2)}, 32'h03);
    checkOutput("t4_pulse", {28'b0, pulseSeen}, 32'b1000);
    checkOutput("t4_width", pulseCount, 32'd1);
    pulseCount = 0; pulseSeen = '0;
    applyStimulus(8'd2, "t4b");
    checkOutput("t4_repeat", pulseCount, 32'd1);
    pulseCount = 0; pulseSeen = '0;
    words = '{8'h00};
    applyStimulus(8'd2, "t4c");
    checkOutput("t4_pulse0", {28'b0, pulseSeen}, 32'b0001);
    pulseCount = 0; pulseSeen = '0;
    words = '{8'h07};
    applyStimulus(8'd2, "t4d");
    checkOutput("t4_reg2b", {24'b0, reg8(2)}, 32'h07);
    checkOutput("t4_nopulse", pulseCount, 32'd0);

    // Abandoned frame after 4 data bits, then a clean frame.
    sendWord(16'h0005, 8, rd);
    sendWord(16'h000A, 4, rd);
    checkOutput("t5_active", {31'b0, frame_active}, 32'd1);
    endFrame("t5");
    checkOutput("t5_kept", {24'b0, reg8(5)}, 32'd0);
    words = '{8'h5A};
    applyStimulus(8'd5, "t5b");
    checkOutput("t5_new", {24'b0, reg8(5)}, 32'h5A);

`ifdef SPI_PARITY_EN
    // Bad parity on reg 3 is dropped and sticky; the pointer still advances to 4.
    sendWord(16'h0003, 8, rd);
    sendWord({7'b0, 8'hEE, ^8'hEE}, 9, rd);
    sendWord(dataWord(8'h44), 9, rd);
    endFrame("tp");
    checkOutput("tp_reg3", {24'b0, reg8(3)}, 32'd0);
    checkOutput("tp_reg4", {24'b0, reg8(4)}, 32'h44);
    checkOutput("tp_err", {31'b0, err_parity}, 32'd1);
`endif

    // Reset in the middle of a read frame of reg 1 (MSB of 0xA5 is 1).
    sendWord(16'h0081, 8, rd);
    waitCycles(8);
    checkOutput("t6_msb", {31'b0, spiBus.serial_out}, 32'd1);
    rstn = 1'b0;
    waitCycles(1);
    checkOutput("t6_frame", {31'b0, frame_active}, 32'd0);
    checkOutput("t6_sout", {31'b0, spiBus.serial_out}, 32'd0);
    checkOutput("t6_reg1", {24'b0, reg8(1)}, 32'd0);
    checkOutput("t6_reg61", {24'b0, reg8(61)}, 32'd0);
    checkOutput("t6_err", {31'b0, err_parity}, 32'd0);
    rstn = 1'b1;
    waitCycles(2);
    words = '{8'h3C};
    applyStimulus(8'd1, "t6b");
    checkOutput("t6_post", {24'b0, reg8(1)}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
